// File: rtl/mcpu_pkg.sv
// Shared encodings for the microcpu control sequencer.
// Commands, instruction classes, FSM states and field positions.
package mcpu_pkg;

  localparam logic [1:0] CMD_AND = 2'd0;
  localparam logic [1:0] CMD_OR  = 2'd1;
  localparam logic [1:0] CMD_XOR = 2'd2;
  localparam logic [1:0] CMD_ADD = 2'd3;

  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_LDI  = 2'd1;
  localparam logic [1:0] CLS_JMP  = 2'd2;
  localparam logic [1:0] CLS_HALT = 2'd3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  localparam int CLS_MSB = 7;
  localparam int CLS_LSB = 6;
  localparam int CMD_MSB = 5;
  localparam int CMD_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;
  localparam int LRD_MSB = 5;
  localparam int LRD_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 5;
  localparam int TGT_LSB = 0;

endpackage

// File: rtl/mcpu_regfile.sv
// 4-entry register file for the microcpu.
// One write port, three asynchronous read ports.
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [1:0]           wa,
  input  logic [WORD_SIZE-1:0] wd,
  input  logic [1:0]           ra0,
  output logic [WORD_SIZE-1:0] rd0,
  input  logic [1:0]           ra1,
  output logic [WORD_SIZE-1:0] rd1,
  input  logic [1:0]           ra2,
  output logic [WORD_SIZE-1:0] rd2
);

  logic [WORD_SIZE-1:0] r [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else if (we) begin
      r[wa] <= wd;
    end
  end

  assign rd0 = r[ra0];
  assign rd1 = r[ra1];
  assign rd2 = r[ra2];

endmodule

// File: rtl/mcpu_ctrl_seq.sv
// Fetch/decode/issue sequencer feeding MCPU_Alu.
// Three cycles per instruction: FETCH, DECODE, EXEC.
module mcpu_ctrl_seq
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE   = 2,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_SIZE  = 6,
  parameter int INSTR_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDR_SIZE-1:0]   instr_addr,
  output logic                   instr_rd,
  input  logic [INSTR_SIZE-1:0]  instr_data,
  output logic [CMD_SIZE-1:0]    alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_r1,
  output logic [WORD_SIZE-1:0]   alu_r2,
  input  logic [2*WORD_SIZE-1:0] alu_out,
  input  logic                   alu_overflow,
  output logic                   busy,
  output logic                   halted,
  output logic                   ovf_flag,
  input  logic [1:0]             dbg_sel,
  output logic [WORD_SIZE-1:0]   dbg_data
);

  logic [2:0]            state, state_nx;
  logic [ADDR_SIZE-1:0]  pc;
  logic [INSTR_SIZE-1:0] ir;
  logic [1:0]            cls;
  logic                  we;
  logic [1:0]            wa;
  logic [WORD_SIZE-1:0]  wd;
  logic [WORD_SIZE-1:0]  rd_data;
  logic [WORD_SIZE-1:0]  rs_data;
  logic                  unused_alu_hi;

  assign cls           = ir[CLS_MSB:CLS_LSB];
  assign instr_addr    = pc;
  assign instr_rd      = (state == FETCH);
  assign busy          = (state == FETCH) ||
                         (state == DECODE) ||
                         (state == EXEC);
  assign halted        = (state == HALT);
  assign unused_alu_hi = ^alu_out[2*WORD_SIZE-1:WORD_SIZE];

  // Operands are read straight off the ROM data during DECODE
  mcpu_regfile #(.WORD_SIZE(WORD_SIZE)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra0   (instr_data[RD_MSB:RD_LSB]),
    .rd0   (rd_data),
    .ra1   (instr_data[RS_MSB:RS_LSB]),
    .rd1   (rs_data),
    .ra2   (dbg_sel),
    .rd2   (dbg_data)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE,
      HALT:    if (start) state_nx = FETCH;
      FETCH:   state_nx = DECODE;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = (cls == CLS_HALT) ? HALT : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    we = 1'b0;
    wa = ir[RD_MSB:RD_LSB];
    wd = alu_out[WORD_SIZE-1:0];
    if (state == EXEC) begin
      unique case (1'b1)
        cls == CLS_ALU: we = 1'b1;
        cls == CLS_LDI: begin
          we = 1'b1;
          wa = ir[LRD_MSB:LRD_LSB];
          wd = WORD_SIZE'(ir[IMM_MSB:IMM_LSB]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      alu_opcode <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      ovf_flag   <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE || state == HALT) && start) begin
        pc       <= '0;
        ovf_flag <= 1'b0;
      end
      if (state == DECODE) begin
        ir <= instr_data;
        if (instr_data[CLS_MSB:CLS_LSB] == CLS_ALU) begin
          alu_opcode <= CMD_SIZE'(instr_data[CMD_MSB:CMD_LSB]);
          alu_r1     <= rd_data;
          alu_r2     <= rs_data;
        end
      end
      if (state == EXEC) begin
        unique case (1'b1)
          cls == CLS_ALU: begin
            ovf_flag <= ovf_flag | alu_overflow;
            pc       <= pc + ADDR_SIZE'(1);
          end
          cls == CLS_LDI: pc <= pc + ADDR_SIZE'(1);
          cls == CLS_JMP: pc <= ADDR_SIZE'(ir[TGT_MSB:TGT_LSB]);
          default: ;
        endcase
      end
    end
  end

endmodule
